// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory arbiter: FSM state type and
// parameter defaults.
package imem_pkg;

    // BOOT: loader owns the memory and the core is held.
    // RUN: core fetches, and the loader gets a share of the port.
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned DEF_MEM_WORDS    = 8;
    localparam int unsigned DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter. It shares one memory port between
// the core fetch path (reads) and a byte-wide boot loader (writes). A BOOT/RUN
// FSM decides who may use the port. A starvation counter stops fetch traffic
// from locking the loader out indefinitely while in RUN.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned MEM_WORDS    = DEF_MEM_WORDS,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                         clk,
    input  logic                         rst,
    // core fetch port
    input  logic                         fetch_req,
    input  logic [31:0]                  fetch_addr,
    output logic                         fetch_gnt,
    output logic                         fetch_rvalid,
    output logic [31:0]                  fetch_rdata,
    output logic                         fetch_err,
    // boot loader port
    input  logic                         load_req,
    input  logic [31:0]                  load_addr,
    input  logic [7:0]                   load_wdata,
    output logic                         load_gnt,
    input  logic                         load_done,
    input  logic                         reload_req,
    output logic                         core_hold,
    // single-port memory
    output logic                         mem_en,
    output logic [3:0]                   mem_we,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
    output logic [31:0]                  mem_wdata,
    input  logic [31:0]                  mem_rdata
);

    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [SW-1:0] r_starve;
    logic          r_rvalid;
    logic          r_err;
    logic          w_fetch_gnt;
    logic          w_load_gnt;
    logic          w_starved;
    logic          w_unused;

    // Address bits above the memory depth are ignored, so addresses wrap.
    assign w_unused  = ^{fetch_addr[31:AW+2], load_addr[31:AW+2]};

    assign w_starved = (r_starve == SW'(STARVE_LIMIT));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and grant decision. Grants come only from the current
    // requests and registered state. Reset masks every grant.
    always_comb begin
        w_state_nxt = r_state;
        w_fetch_gnt = 1'b0;
        w_load_gnt  = 1'b0;
        if (!rst) begin
            case (r_state)
                BOOT: begin
                    w_load_gnt = load_req;
                    if (load_done) begin
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (load_req && w_starved) begin
                        w_load_gnt = 1'b1;
                    end else if (fetch_req) begin
                        w_fetch_gnt = 1'b1;
                    end else begin
                        w_load_gnt = load_req;
                    end
                    if (reload_req) begin
                        w_state_nxt = BOOT;
                    end
                end
                default: w_state_nxt = BOOT;
            endcase
        end
    end

    // Memory port drive. The port is idle (en/we low) when nothing is granted.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_fetch_gnt) begin
            mem_en   = 1'b1;
            mem_addr = fetch_addr[AW+1:2];
        end else if (w_load_gnt) begin
            mem_en    = 1'b1;
            mem_we    = 4'b0001 << load_addr[1:0];
            mem_wdata = {4{load_wdata}};
            mem_addr  = load_addr[AW+1:2];
        end
    end

    // Saturating count of consecutive RUN cycles in which the loader asked
    // for the port and was refused.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if ((r_state == RUN) && load_req && !w_load_gnt) begin
            if (!w_starved) begin
                r_starve <= r_starve + 1'b1;
            end
        end else begin
            r_starve <= '0;
        end
    end

    // Read response tracking. Data returns one cycle after the grant, along
    // with the misalignment flag for that fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_fetch_gnt;
            r_err    <= w_fetch_gnt && (fetch_addr[1:0] != 2'b00);
        end
    end

    // The response is gated by rst so that asserting reset kills an
    // in-flight read in the same cycle instead of one cycle later.
    assign fetch_rvalid = r_rvalid & ~rst;
    assign fetch_err    = r_err & fetch_rvalid;
    assign fetch_rdata  = fetch_rvalid ? mem_rdata : '0;
    assign fetch_gnt    = w_fetch_gnt;
    assign load_gnt     = w_load_gnt;
    assign core_hold    = rst | (r_state == BOOT);

endmodule

// File: tb/tb_imem_arbiter.sv
// Testbench for imem_arbiter: directed boot/fetch/starvation/reload/reset
// scenarios followed by random traffic, all checked against a byte-level
// reference model of the arbitration rules.
module tb_imem_arbiter;

    localparam int unsigned W   = 8;
    localparam int unsigned LIM = 4;

    logic        clk;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_rvalid;
    logic [31:0] fetch_rdata;
    logic        fetch_err;
    logic        load_req;
    logic [31:0] load_addr;
    logic [7:0]  load_wdata;
    logic        load_gnt;
    logic        load_done;
    logic        reload_req;
    logic        core_hold;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [2:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    imem_arbiter #(.MEM_WORDS(W), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
        .load_req(load_req), .load_addr(load_addr), .load_wdata(load_wdata),
        .load_gnt(load_gnt), .load_done(load_done), .reload_req(reload_req),
        .core_hold(core_hold),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical single-port memory attached to the DUT.
    logic [31:0] bmem [W];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == 4'b0000) begin
                mem_rdata <= bmem[mem_addr];
            end else begin
                for (int l = 0; l < 4; l++) begin
                    if (mem_we[l]) bmem[mem_addr][l*8 +: 8] <= mem_wdata[l*8 +: 8];
                end
            end
        end
    end

    // Reference model state.
    bit          m_run;
    int          m_starve;
    bit          m_pv;
    bit          m_pe;
    bit [31:0]   m_pw;
    byte unsigned m_mem [W*4];

    int n_checks = 0;
    int n_errors = 0;
    logic s_fg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: predict, check mid-cycle, then advance the model.
    task automatic step();
        bit          e_fg, e_lg, e_hold, e_rv;
        bit [31:0]   e_rd, e_addr;
        int          widx;
        e_fg = 0;
        e_lg = 0;
        if (!rst) begin
            if (!m_run) begin
                e_lg = load_req;
            end else if (load_req && m_starve >= int'(LIM)) begin
                e_lg = 1;
            end else if (fetch_req) begin
                e_fg = 1;
            end else begin
                e_lg = load_req;
            end
        end
        e_hold = rst || !m_run;
        e_rv   = m_pv && !rst;
        e_rd   = e_rv ? m_pw : 32'h0;
        e_addr = e_fg ? (fetch_addr >> 2) % W : (load_addr >> 2) % W;

        @(negedge clk);
        s_fg = fetch_gnt;
        chk("core_hold", 32'(core_hold), 32'(e_hold));
        chk("fetch_gnt", 32'(fetch_gnt), 32'(e_fg));
        chk("load_gnt", 32'(load_gnt), 32'(e_lg));
        chk("mem_en", 32'(mem_en), 32'(e_fg | e_lg));
        chk("mem_we", 32'(mem_we), e_lg ? (32'h1 << load_addr[1:0]) : 32'h0);
        if (e_fg || e_lg) chk("mem_addr", 32'(mem_addr), e_addr);
        if (e_lg) chk("mem_wdata", mem_wdata, {4{load_wdata}});
        chk("fetch_rvalid", 32'(fetch_rvalid), 32'(e_rv));
        chk("fetch_rdata", fetch_rdata, e_rd);
        chk("fetch_err", 32'(fetch_err), 32'(e_rv && m_pe));

        @(posedge clk);
        if (rst) begin
            m_run = 0; m_starve = 0; m_pv = 0; m_pe = 0;
        end else begin
            m_pv = e_fg;
            m_pe = e_fg && (fetch_addr[1:0] != 2'b00);
            if (e_fg) begin
                widx = int'((fetch_addr >> 2) % W);
                m_pw = {m_mem[widx*4+3], m_mem[widx*4+2], m_mem[widx*4+1], m_mem[widx*4]};
            end
            if (e_lg) m_mem[int'(load_addr % (W*4))] = load_wdata;
            if (m_run && load_req && !e_lg) m_starve = (m_starve + 1 > int'(LIM)) ? int'(LIM) : m_starve + 1;
            else m_starve = 0;
            if (!m_run && load_done) m_run = 1;
            else if (m_run && reload_req) m_run = 0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        fetch_req = 0; load_req = 0; load_done = 0; reload_req = 0;
    endtask

    byte unsigned boot_img [W*4];

    initial begin
        rst = 1; idle_inputs();
        fetch_addr = '0; load_addr = '0; load_wdata = '0;
        m_run = 0; m_starve = 0; m_pv = 0; m_pe = 0; m_pw = '0;
        for (int i = 0; i < int'(W*4); i++) begin
            m_mem[i] = 8'h00;
            boot_img[i] = 8'($urandom);
        end
        boot_img[0] = 8'h13; boot_img[1] = 8'h00; boot_img[2] = 8'h00; boot_img[3] = 8'h00;
        boot_img[8] = 8'h93; boot_img[9] = 8'h00; boot_img[10] = 8'h50; boot_img[11] = 8'h00;
        #1;
        // Reset: held state with no grants even if requests are present.
        load_req = 1; fetch_req = 1;
        step(); step();
        rst = 0; idle_inputs();

        // Boot image load, every byte; some addresses carry junk upper bits.
        for (int i = 0; i < int'(W*4); i++) begin
            load_req = 1;
            load_addr = 32'(i) + ((i >= 4) ? (32'($urandom_range(0, 15)) << 5) : 32'h0);
            load_wdata = boot_img[i];
            step();
        end
        // End of boot, a final write granted in the same cycle.
        load_addr = 32'd4; load_wdata = boot_img[4]; load_done = 1;
        step();
        idle_inputs();
        step();

        // Fetch latency at 0x8.
        fetch_req = 1; fetch_addr = 32'h8;
        step();
        fetch_req = 0;
        chk("fetch_lat_rdata", fetch_rdata, 32'h00500093);
        step();

        // Starvation: fetch and load both held high.
        fetch_req = 1; fetch_addr = 32'h4; load_req = 1; load_addr = 32'h1C; load_wdata = boot_img[28];
        for (int k = 0; k < 10; k++) begin
            step();
            chk("starve_pattern", 32'(s_fg), 32'((k % 5) != 4));
        end
        idle_inputs();
        step();

        // Misaligned fetch with wrap-around.
        fetch_req = 1; fetch_addr = 32'h22;
        step();
        fetch_req = 0;
        chk("misalign_err", 32'(fetch_err), 32'h1);
        step();

        // Reload in the cycle after a fetch grant.
        fetch_req = 1; fetch_addr = 32'h10;
        step();
        fetch_req = 0; reload_req = 1;
        step();
        reload_req = 0; fetch_req = 1;
        step(); step();
        idle_inputs();

        // Back to RUN, then reset in the cycle after a fetch grant.
        load_done = 1;
        step();
        load_done = 0; fetch_req = 1; fetch_addr = 32'h0;
        step();
        rst = 1; fetch_req = 0;
        step();
        rst = 0;
        step(); step();

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            rst        = ($urandom_range(0, 99) == 0);
            fetch_req  = ($urandom_range(0, 3) != 0);
            fetch_addr = $urandom;
            load_req   = ($urandom_range(0, 2) == 0);
            load_addr  = $urandom;
            load_wdata = 8'($urandom);
            load_done  = ($urandom_range(0, 9) == 0);
            reload_req = ($urandom_range(0, 29) == 0);
            step();
        end
        rst = 0; idle_inputs();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 8, meaning instruction memory depth in 32-bit words (power of two, >=2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive denied loader cycles before the loader is forced a grant.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port fetch_req, input, 1, fetch read request.
REQ-006 SHALL have port fetch_addr, input, 32, byte address from the PC.
REQ-007 SHALL have port fetch_gnt, output, 1, fetch request accepted this cycle.
REQ-008 SHALL have port fetch_rvalid, output, 1, read data valid.
REQ-009 SHALL have port fetch_rdata, output, 32, instruction word.
REQ-010 SHALL have port fetch_err, output, 1, misaligned fetch flag, qualified by fetch_rvalid.
REQ-011 SHALL have port load_req, input, 1, loader byte-write request.
REQ-012 SHALL have port load_addr, input, 32, loader byte address.
REQ-013 SHALL have port load_wdata, input, 8, loader byte.
REQ-014 SHALL have port load_gnt, output, 1, loader write accepted this cycle.
REQ-015 SHALL have port load_done, input, 1, single-cycle pulse ending boot load.
REQ-016 SHALL have port reload_req, input, 1, single-cycle pulse re-entering boot load.
REQ-017 SHALL have port core_hold, output, 1, high while the core must not fetch.
REQ-018 SHALL have ports mem_en (1), mem_we (4, byte enables), mem_addr ($clog2(MEM_WORDS)), mem_wdata (32), all outputs, and mem_rdata (32), input, forming the single-port memory interface; mem_rdata is valid one cycle after mem_en with mem_we==0.

Function
REQ-019 SHALL implement FSM states BOOT and RUN.
REQ-020 SHALL in BOOT hold core_hold=1, grant only the loader, and keep fetch_gnt=0.
REQ-021 SHALL move BOOT->RUN on load_done; a loader write granted in the same cycle completes.
REQ-022 SHALL move RUN->BOOT on reload_req; a read granted in the previous cycle still returns fetch_rvalid.
REQ-023 SHALL give load_done priority when load_done and reload_req are both high in BOOT (go RUN), and reload_req priority in RUN (go BOOT).
REQ-024 SHALL in RUN grant at most one requester per cycle, with fetch having priority unless the starvation counter equals STARVE_LIMIT, in which case the loader is granted.
REQ-025 SHALL keep a saturating starvation counter that increments each RUN cycle in which load_req=1 and load_gnt=0, and clears on load_gnt or load_req=0.
REQ-026 SHALL, on fetch grant, drive mem_en=1, mem_we=0, and mem_addr=fetch_addr word index modulo MEM_WORDS (upper bits ignored, wrap-around).
REQ-027 SHALL assert fetch_rvalid exactly one cycle after fetch_gnt, with fetch_rdata=mem_rdata; fetch_rdata is 0 when fetch_rvalid=0.
REQ-028 SHALL set fetch_err=1 with that fetch_rvalid when the granted fetch_addr[1:0]!=0; the data is still returned.
REQ-029 SHALL, on loader grant, drive mem_en=1, mem_we one-hot at bit load_addr[1:0], mem_wdata = load_wdata replicated to all 4 lanes, and mem_addr = load_addr word index modulo MEM_WORDS.
REQ-030 SHALL make grants combinational from current requests and registered state; a write in cycle N is visible to a fetch granted in cycle N+1.
REQ-031 SHALL drive mem_en=0 and mem_we=0 in every cycle with no grant.

Reset
REQ-032 SHALL on rst enter BOOT and set the starvation counter to 0, fetch_rvalid=0, fetch_err=0, and fetch_rdata=0.
REQ-033 SHALL hold core_hold=1 and fetch_gnt=load_gnt=mem_en=0 and mem_we=0 during reset.
REQ-034 SHALL cancel any pending fetch_rvalid when rst is asserted mid-operation.

Structure
REQ-035 SHALL place the state enum (BOOT, RUN) and the defaults for MEM_WORDS and STARVE_LIMIT in a shared package imem_pkg.
REQ-036 SHALL be a single module with no sub-module; the starvation counter and the FSM are local.

Verification
REQ-037 SHALL cover boot write: after reset, 4 loader writes of 0x13,0x00,0x00,0x00 to addresses 0..3 -> mem_we 0001,0010,0100,1000 at mem_addr 0; then load_done -> core_hold=0 on the next cycle.
REQ-038 SHALL cover fetch latency: in RUN, fetch_addr=0x8 with mem_rdata=0x00500093 -> mem_addr=2 in the grant cycle, fetch_rvalid=1 and fetch_rdata=0x00500093 one cycle later.
REQ-039 SHALL cover starvation: fetch_req and load_req both held high in RUN -> 4 fetch grants, then 1 load_gnt, then the pattern repeats.
REQ-040 SHALL cover misaligned fetch and wrap-around: fetch_addr=0x22 with MEM_WORDS=8 -> mem_addr=0, fetch_err=1 with fetch_rvalid.
REQ-041 SHALL cover reload: reload_req in the cycle after a fetch grant -> fetch_rvalid still asserted, BOOT entered, and fetch_gnt=0 thereafter.
REQ-042 SHALL cover mid-operation reset: rst in the cycle after a fetch grant -> fetch_rvalid=0 and BOOT entered.
